vedic_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8x8 combinational Vedic multiplier.
- Computes c = a*b with WIDTH-bit operands using Urdhva-Tiryagbhyam recursive decomposition into four half-width sub-products.
- Supports a per-transaction signed/unsigned mode.
- Sits between an operand producer and a result consumer, with valid/ready handshakes and a sideband tag on both sides.

---
 rtl/vedic_mult_pipe.sv | 157 +++++++++++++++
 tb/tb_vedic_mult_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Vedic (Urdhva-Tiryagbhyam) multiplier with
// per-beat signed/unsigned mode, valid/ready handshakes and a sideband tag.
module vedic_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int H  = int'(WIDTH) / 2;
  localparam int ND = H / 2;
  localparam int PW = 2 * int'(WIDTH);

  // 2x2 leaf cell: vertical and crosswise partial products with explicit carries.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic k1, s1, k2;
    k1 = (x[1] & y[0]) & (x[0] & y[1]);
    s1 = (x[1] & y[1]) ^ k1;
    k2 = (x[1] & y[1]) & k1;
    return {k2, s1, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction

  // Builds the HxH product bottom-up: each level merges 2x2 groups of block
  // products into one block of twice the size, down from 2x2 leaf cells.
  function automatic logic [WIDTH-1:0] vedic_half(input logic [H-1:0] x,
                                                  input logic [H-1:0] y);
    logic [WIDTH-1:0] p [ND][ND];
    logic [WIDTH-1:0] t [ND][ND];
    for (int i = 0; i < ND; i++) begin
      for (int j = 0; j < ND; j++) begin
        p[i][j] = WIDTH'(vedic2(x[2*i +: 2], y[2*j +: 2]));
      end
    end
    for (int blk = 2; blk < H; blk = blk * 2) begin
      t = p;
      for (int i = 0; i < H / (2 * blk); i++) begin
        for (int j = 0; j < H / (2 * blk); j++) begin
          p[i][j] = (t[2*i+1][2*j+1] << (2 * blk))
                  + ((t[2*i+1][2*j] + t[2*i][2*j+1]) << blk)
                  + t[2*i][2*j];
        end
      end
    end
    return p[0][0];
  endfunction

  logic               stall;
  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic               neg1_q, neg1_d, neg2_q, neg2_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [WIDTH-1:0]   hh_q, hh_d, hl_q, hl_d, lh_q, lh_d, ll_q, ll_d;
  logic [TAG_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [2*WIDTH-1:0] c_q, c_d, prod;

  always_comb begin
    stall    = v3_q & ~out_ready;
    in_ready = ~stall;

    v1_d   = v1_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    neg1_d = neg1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    hh_d   = hh_q;
    hl_d   = hl_q;
    lh_d   = lh_q;
    ll_d   = ll_q;
    neg2_d = neg2_q;
    tag2_d = tag2_q;
    v3_d   = v3_q;
    c_d    = c_q;
    tag3_d = tag3_q;

    prod = {hh_q, {WIDTH{1'b0}}}
         + ((PW'(hl_q) + PW'(lh_q)) << H)
         + PW'(ll_q);

    // Global enable: a stall freezes every stage, bubbles included.
    if (!stall) begin
      v1_d = in_valid;
      if (in_valid) begin
        ma_d   = (sgn & a[WIDTH-1]) ? -a : a;
        mb_d   = (sgn & b[WIDTH-1]) ? -b : b;
        neg1_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        tag1_d = in_tag;
      end

      v2_d = v1_q;
      if (v1_q) begin
        hh_d   = vedic_half(ma_q[WIDTH-1:H], mb_q[WIDTH-1:H]);
        hl_d   = vedic_half(ma_q[WIDTH-1:H], mb_q[H-1:0]);
        lh_d   = vedic_half(ma_q[H-1:0], mb_q[WIDTH-1:H]);
        ll_d   = vedic_half(ma_q[H-1:0], mb_q[H-1:0]);
        neg2_d = neg1_q;
        tag2_d = tag1_q;
      end

      v3_d = v2_q;
      if (v2_q) begin
        c_d    = neg2_q ? -prod : prod;
        tag3_d = tag2_q;
      end
    end

    out_valid = v3_q;
    c         = c_q;
    out_tag   = tag3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      neg1_q <= 1'b0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      hh_q   <= '0;
      hl_q   <= '0;
      lh_q   <= '0;
      ll_q   <= '0;
      neg2_q <= 1'b0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      c_q    <= '0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      neg1_q <= neg1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      hh_q   <= hh_d;
      hl_q   <= hl_d;
      lh_q   <= lh_d;
      ll_q   <= ll_d;
      neg2_q <= neg2_d;
      tag2_q <= tag2_d;
      v3_q   <= v3_d;
      c_q    <= c_d;
      tag3_q <= tag3_d;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: directed WIDTH=8 vectors and corner sequences, plus
// randomized sweeps at WIDTH=4/16/32 against a sign-extend-and-multiply model.
module tb_vedic_mult_pipe;
  typedef struct {
    logic [63:0] c;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go  = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input int w);
    logic [63:0] xe, ye, m;
    xe = x;
    ye = y;
    if (s && x[w-1]) xe = x | (~64'd0 << w);
    if (s && y[w-1]) ye = y | (~64'd0 << w);
    m = (2 * w >= 64) ? ~64'd0 : ((64'd1 << (2 * w)) - 64'd1);
    return (xe * ye) & m;
  endfunction

  // WIDTH = 8 instance for directed tests
  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  t8 = '0, to8;
  logic [15:0] c8;
  exp_t        q8[$];
  bit          lat8 = 1'b0;

  vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sgn(s8),
    .in_tag(t8), .out_valid(ov8), .out_ready(ordy8), .c(c8), .out_tag(to8)
  );

  task automatic step8(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic is, input logic [3:0] it, input logic [15:0] ec,
                       input logic ordy, output logic accepted);
    exp_t e;
    @(posedge clk);
    #1;
    iv8 = v; a8 = ia; b8 = ib; s8 = is; t8 = it; ordy8 = ordy;
    @(negedge clk);
    if (ov8 && ordy8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_out", 64'(ov8), 64'd0);
      end else begin
        e = q8.pop_front();
        chk("w8_c", 64'(c8), e.c);
        chk("w8_tag", 64'(to8), 64'(e.tag));
        if (lat8) chk("w8_latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
    accepted = iv8 && ir8;
    if (accepted) q8.push_back('{c: 64'(ec), tag: it, cyc: cyc});
  endtask

  // Randomized sweeps at other widths
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    logic           iv, ir, ov, ordy, s;
    logic [W-1:0]   a, b;
    logic [3:0]     ti, to;
    logic [2*W-1:0] c;
    bit             fin = 1'b0;

    vedic_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .sgn(s),
      .in_tag(ti), .out_valid(ov), .out_ready(ordy), .c(c), .out_tag(to)
    );

    initial begin
      exp_t q[$];
      exp_t e;
      int   acc;
      int   guard;
      iv = 1'b0; ordy = 1'b1; s = 1'b0; a = '0; b = '0; ti = '0;
      wait (go);
      acc = 0;
      guard = 0;
      while ((acc < 1000 || q.size() != 0) && guard < 20000) begin
        guard++;
        @(posedge clk);
        #1;
        iv   = (acc < 1000) && ($urandom_range(3) != 0);
        a    = W'($urandom);
        b    = W'($urandom);
        s    = 1'($urandom);
        ti   = 4'($urandom);
        ordy = (acc < 1000) ? ($urandom_range(3) != 0) : 1'b1;
        @(negedge clk);
        if (ov && ordy) begin
          if (q.size() == 0) begin
            chk($sformatf("sw%0d_unexpected_out", W), 64'(ov), 64'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("sw%0d_c", W), 64'(c), e.c);
            chk($sformatf("sw%0d_tag", W), 64'(to), 64'(e.tag));
          end
        end
        if (iv && ir) begin
          q.push_back('{c: ref_mul(64'(a), 64'(b), s, W), tag: ti, cyc: cyc});
          acc++;
        end
      end
      chk($sformatf("sw%0d_ops", W), 64'(acc), 64'd1000);
      chk($sformatf("sw%0d_drain", W), 64'(q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    vec_t        tbl [11];
    logic        acc;
    int          sent;
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] cc;
    logic [3:0]  tt;

    tbl[0]  = '{8'd5,   8'd3,   1'b0, 16'd15};
    tbl[1]  = '{8'd255, 8'd255, 1'b0, 16'hFE01};
    tbl[2]  = '{8'd0,   8'd0,   1'b0, 16'd0};
    tbl[3]  = '{8'd4,   8'd2,   1'b0, 16'd8};
    tbl[4]  = '{8'd6,   8'd8,   1'b0, 16'd48};
    tbl[5]  = '{8'hFB,  8'h03,  1'b1, 16'hFFF1};
    tbl[6]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    tbl[7]  = '{8'h80,  8'hFF,  1'b1, 16'h0080};
    tbl[8]  = '{8'h7F,  8'h81,  1'b1, 16'hC0FF};
    tbl[9]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    tbl[10] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};

    cc = '0;
    tt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_c", 64'(c8), 64'd0);
    chk("rst_out_tag", 64'(to8), 64'd0);
    chk("rst_in_ready", 64'(ir8), 64'd1);

    // Back-to-back table with fixed-latency check
    lat8 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step8(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, 4'(i), tbl[i].c, 1'b1, acc);
      chk("tbl_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 5; i++) step8(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0, 1'b1, acc);
    chk("tbl_drain", 64'(q8.size()), 64'd0);

    // Backpressure: fill, stall 5 cycles, then drain
    lat8 = 1'b0;
    sent = 0;
    for (int k = 0; k < 20 && !ov8 && sent < 6; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      step8(1'b1, ra, rb, rs, 4'(sent), 16'(ref_mul(64'(ra), 64'(rb), rs, 8)), 1'b1, acc);
      if (acc) sent++;
    end
    chk("bp_out_valid_rise", 64'(ov8), 64'd1);
    for (int k = 0; k < 5; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      step8(sent < 6, ra, rb, rs, 4'(sent), 16'(ref_mul(64'(ra), 64'(rb), rs, 8)), 1'b0, acc);
      if (acc) sent++;
      chk("bp_in_ready", 64'(ir8), 64'd0);
      chk("bp_out_valid", 64'(ov8), 64'd1);
      if (k == 0) begin
        cc = c8;
        tt = to8;
      end else begin
        chk("bp_c_hold", 64'(c8), 64'(cc));
        chk("bp_tag_hold", 64'(to8), 64'(tt));
      end
    end
    for (int k = 0; k < 30 && (sent < 6 || q8.size() != 0); k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      step8(sent < 6, ra, rb, rs, 4'(sent), 16'(ref_mul(64'(ra), 64'(rb), rs, 8)), 1'b1, acc);
      if (acc) sent++;
    end
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_drain", 64'(q8.size()), 64'd0);

    // Reset with three operations in flight
    lat8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step8(1'b1, 8'(k + 7), 8'd9, 1'b0, 4'(k), 16'((k + 7) * 9), 1'b1, acc);
    end
    rst = 1'b1;
    iv8 = 1'b0;
    q8.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step8(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0, 1'b1, acc);
      chk("rst_mid_no_out", 64'(ov8), 64'd0);
    end
    step8(1'b1, 8'd2, 8'd2, 1'b0, 4'hA, 16'd4, 1'b1, acc);
    chk("rst_mid_accept", 64'(acc), 64'd1);
    for (int k = 0; k < 4; k++) step8(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0, 1'b1, acc);
    chk("rst_mid_drain", 64'(q8.size()), 64'd0);

    go = 1'b1;
    for (int i = 0; i < 60000 && !(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin); i++) begin
      @(posedge clk);
    end
    chk("sweep_done", 64'({g_sw[0].fin, g_sw[1].fin, g_sw[2].fin}), 64'd7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
